// File: rtl/cpu_pipe_pkg.sv
// Shared widths, control-field encodings and payload sizing for the 8-bit CPU pipeline.
package cpu_pipe_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int PC_W       = 8;
    localparam int ALU_CTL_W  = 3;
    localparam int CTL2_W     = 2;

    typedef enum logic [1:0] {
        JCTL_NONE = 2'b00,
        JCTL_JMP  = 2'b01,
        JCTL_JZ   = 2'b10,
        JCTL_JNZ  = 2'b11
    } jctl_e;

    typedef enum logic [1:0] {
        IM_NONE = 2'b00,
        IM_LOW  = 2'b01,
        IM_HIGH = 2'b10,
        IM_FULL = 2'b11
    } im_ctl_e;

    typedef enum logic [1:0] {
        STK_NONE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_CALL = 2'b11
    } stack_ctl_e;

    // Three register addresses, three 2-bit mode fields and five 1-bit enables/selects.
    function automatic int payload_width(input int ra_w, input int d_w, input int a_w,
                                         input int pc_w, input int alu_w);
        return 3 * ra_w + d_w + a_w + pc_w + alu_w + 3 * CTL2_W + 5;
    endfunction

    localparam int PAYLOAD_W = payload_width(REG_ADDR_W, DATA_W, ADDR_W, PC_W, ALU_CTL_W);

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic two-slot (main + skid) valid/ready register; in_ready comes straight from the skid valid flop.
module pipe_skid_buffer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         vld_p0;
    logic         vld_p1;
    logic [W-1:0] main_p0;
    logic [W-1:0] skid_p1;
    logic         accept;
    logic         drain;

    assign accept = in_valid & ~vld_p1;
    assign drain  = vld_p0 & out_ready;

    // Stage boundary: main slot drives execute, skid slot absorbs the beat in flight during a stall.
    always_ff @(negedge CLK) begin
        if (RST) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            main_p0 <= '0;
            skid_p1 <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (vld_p1) begin
            if (drain) begin
                main_p0 <= skid_p1;
                vld_p1  <= 1'b0;
            end
        end else if (accept) begin
            if (!vld_p0 || drain) begin
                main_p0 <= in_data;
                vld_p0  <= 1'b1;
            end else begin
                skid_p1 <= in_data;
                vld_p1  <= 1'b1;
            end
        end else if (drain) begin
            vld_p0 <= 1'b0;
        end
    end

    assign in_ready  = ~vld_p1;
    assign out_valid = vld_p0;
    assign out_data  = main_p0;

endmodule

// File: rtl/decode_exec_pipe_reg.sv
// Decode-to-execute register: packs the decoded bundle through a skid buffer, handles flush,
// masks side-effecting enables on empty slots and counts stalled edges for debug.
module decode_exec_pipe_reg #(
    parameter int REG_ADDR_W  = cpu_pipe_pkg::REG_ADDR_W,
    parameter int DATA_W      = cpu_pipe_pkg::DATA_W,
    parameter int ADDR_W      = cpu_pipe_pkg::ADDR_W,
    parameter int PC_W        = cpu_pipe_pkg::PC_W,
    parameter int ALU_CTL_W   = cpu_pipe_pkg::ALU_CTL_W,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_ADDR_W-1:0]  a_addr_in,
    input  logic [REG_ADDR_W-1:0]  b_addr_in,
    input  logic [REG_ADDR_W-1:0]  c_addr_in,
    input  logic [DATA_W-1:0]      immediate_val_in,
    input  logic [ADDR_W-1:0]      addr_in,
    input  logic [PC_W-1:0]        PC_in,
    input  logic [ALU_CTL_W-1:0]   alu_control_in,
    input  logic [1:0]             JCTL_in,
    input  logic [1:0]             im_ctl_in,
    input  logic [1:0]             stack_ctl_in,
    input  logic                   reg_write_in,
    input  logic                   data_read_in,
    input  logic                   data_write_in,
    input  logic                   reg_addr_in,
    input  logic                   stack_command_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REG_ADDR_W-1:0]  a_addr,
    output logic [REG_ADDR_W-1:0]  b_addr,
    output logic [REG_ADDR_W-1:0]  c_addr,
    output logic [DATA_W-1:0]      immediate_val,
    output logic [ADDR_W-1:0]      addr,
    output logic [PC_W-1:0]        PC,
    output logic [ALU_CTL_W-1:0]   alu_control,
    output logic [1:0]             JCTL,
    output logic [1:0]             im_ctl,
    output logic [1:0]             stack_ctl,
    output logic                   reg_write,
    output logic                   data_read,
    output logic                   data_write,
    output logic                   reg_addr,
    output logic                   stack_command,
    output logic [STALL_CNT_W-1:0] stall_count
);

    import cpu_pipe_pkg::payload_width;

    localparam int PAYLOAD_W = payload_width(REG_ADDR_W, DATA_W, ADDR_W, PC_W, ALU_CTL_W);

    logic [PAYLOAD_W-1:0]   payload_in;
    logic [PAYLOAD_W-1:0]   payload_p0;
    logic                   vld_p0;
    logic                   reg_write_p0;
    logic                   data_read_p0;
    logic                   data_write_p0;
    logic                   stack_command_p0;
    logic [STALL_CNT_W-1:0] stall_cnt_p0;

    assign payload_in = {a_addr_in, b_addr_in, c_addr_in, immediate_val_in, addr_in, PC_in,
                         alu_control_in, JCTL_in, im_ctl_in, stack_ctl_in,
                         reg_write_in, data_read_in, data_write_in, reg_addr_in, stack_command_in};

    pipe_skid_buffer #(
        .W(PAYLOAD_W)
    ) u_skid (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (payload_in),
        .out_valid(vld_p0),
        .out_ready(out_ready),
        .out_data (payload_p0)
    );

    assign {a_addr, b_addr, c_addr, immediate_val, addr, PC,
            alu_control, JCTL, im_ctl, stack_ctl,
            reg_write_p0, data_read_p0, data_write_p0, reg_addr, stack_command_p0} = payload_p0;

    // A squashed or empty slot keeps its stale payload, so anything with side effects is masked.
    assign out_valid     = vld_p0;
    assign reg_write     = reg_write_p0 & vld_p0;
    assign data_read     = data_read_p0 & vld_p0;
    assign data_write    = data_write_p0 & vld_p0;
    assign stack_command = stack_command_p0 & vld_p0;

    // Stage boundary: debug stall counter, sticky at all-ones until reset.
    always_ff @(negedge CLK) begin
        if (RST) begin
            stall_cnt_p0 <= '0;
        end else if (vld_p0 && !out_ready && (stall_cnt_p0 != '1)) begin
            stall_cnt_p0 <= stall_cnt_p0 + STALL_CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_p0;

endmodule

// File: tb/tb_decode_exec_pipe_reg.sv
// Scoreboard bench for decode_exec_pipe_reg: default instance for directed flow/flush/reset cases,
// wide instance (REG_ADDR_W=5, DATA_W=16, STALL_CNT_W=4) for saturation and random traffic.
module tb_decode_exec_pipe_reg;

    typedef struct packed {
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic [15:0] imm;
        logic [7:0]  addr;
        logic [7:0]  pc;
        logic [2:0]  alu;
        logic [1:0]  jctl;
        logic [1:0]  imc;
        logic [1:0]  stk;
        logic        rw;
        logic        dr;
        logic        dw;
        logic        ra;
        logic        sc;
    } beat_t;

    logic CLK = 1'b1;
    logic RST;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int n_push2 = 0;
    int n_pop2  = 0;
    beat_t q[$];
    beat_t q2[$];
    beat_t cur, cur2;
    logic  last_acc;

    // Default-width instance signals
    logic       in_valid, in_ready, flush, out_valid, out_ready;
    logic [3:0] a_addr_in, b_addr_in, c_addr_in, a_addr, b_addr, c_addr;
    logic [7:0] immediate_val_in, addr_in, PC_in, immediate_val, addr, PC, stall_count;
    logic [2:0] alu_control_in, alu_control;
    logic [1:0] JCTL_in, im_ctl_in, stack_ctl_in, JCTL, im_ctl, stack_ctl;
    logic       reg_write_in, data_read_in, data_write_in, reg_addr_in, stack_command_in;
    logic       reg_write, data_read, data_write, reg_addr, stack_command;

    // Wide instance signals
    logic        d2_in_valid, d2_in_ready, d2_flush, d2_out_valid, d2_out_ready;
    logic [4:0]  d2_a_in, d2_b_in, d2_c_in, d2_a, d2_b, d2_c;
    logic [15:0] d2_imm_in, d2_imm;
    logic [7:0]  d2_addr_in, d2_pc_in, d2_addr, d2_pc;
    logic [2:0]  d2_alu_in, d2_alu;
    logic [1:0]  d2_jctl_in, d2_imc_in, d2_stk_in, d2_jctl, d2_imc, d2_stk;
    logic        d2_rw_in, d2_dr_in, d2_dw_in, d2_ra_in, d2_sc_in;
    logic        d2_rw, d2_dr, d2_dw, d2_ra, d2_sc;
    logic [3:0]  d2_stall_count;

    decode_exec_pipe_reg dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .a_addr_in(a_addr_in), .b_addr_in(b_addr_in), .c_addr_in(c_addr_in),
        .immediate_val_in(immediate_val_in), .addr_in(addr_in), .PC_in(PC_in),
        .alu_control_in(alu_control_in), .JCTL_in(JCTL_in), .im_ctl_in(im_ctl_in),
        .stack_ctl_in(stack_ctl_in), .reg_write_in(reg_write_in), .data_read_in(data_read_in),
        .data_write_in(data_write_in), .reg_addr_in(reg_addr_in), .stack_command_in(stack_command_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .immediate_val(immediate_val),
        .addr(addr), .PC(PC), .alu_control(alu_control), .JCTL(JCTL), .im_ctl(im_ctl),
        .stack_ctl(stack_ctl), .reg_write(reg_write), .data_read(data_read),
        .data_write(data_write), .reg_addr(reg_addr), .stack_command(stack_command),
        .stall_count(stall_count)
    );

    decode_exec_pipe_reg #(
        .REG_ADDR_W(5), .DATA_W(16), .STALL_CNT_W(4)
    ) dut2 (
        .CLK(CLK), .RST(RST), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .a_addr_in(d2_a_in), .b_addr_in(d2_b_in), .c_addr_in(d2_c_in),
        .immediate_val_in(d2_imm_in), .addr_in(d2_addr_in), .PC_in(d2_pc_in),
        .alu_control_in(d2_alu_in), .JCTL_in(d2_jctl_in), .im_ctl_in(d2_imc_in),
        .stack_ctl_in(d2_stk_in), .reg_write_in(d2_rw_in), .data_read_in(d2_dr_in),
        .data_write_in(d2_dw_in), .reg_addr_in(d2_ra_in), .stack_command_in(d2_sc_in),
        .flush(d2_flush), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .a_addr(d2_a), .b_addr(d2_b), .c_addr(d2_c), .immediate_val(d2_imm),
        .addr(d2_addr), .PC(d2_pc), .alu_control(d2_alu), .JCTL(d2_jctl), .im_ctl(d2_imc),
        .stack_ctl(d2_stk), .reg_write(d2_rw), .data_read(d2_dr),
        .data_write(d2_dw), .reg_addr(d2_ra), .stack_command(d2_sc),
        .stall_count(d2_stall_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] pc, input logic rw, input logic dw);
        beat_t b;
        b.a    = {1'b0, pc[3:0]};
        b.b    = {1'b0, ~pc[3:0]};
        b.c    = {1'b0, pc[7:4]};
        b.imm  = {8'h00, pc ^ 8'h5A};
        b.addr = pc + 8'h80;
        b.pc   = pc;
        b.alu  = pc[2:0];
        b.jctl = pc[1:0];
        b.imc  = pc[2:1];
        b.stk  = ~pc[1:0];
        b.rw   = rw;
        b.dr   = pc[0];
        b.dw   = dw;
        b.ra   = pc[1];
        b.sc   = pc[2];
        return b;
    endfunction

    function automatic beat_t rand_beat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[60:0];
    endfunction

    function automatic logic [63:0] exp1(input beat_t b);
        return {14'b0, b.a[3:0], b.b[3:0], b.c[3:0], b.imm[7:0], b.addr, b.pc, b.alu,
                b.jctl, b.imc, b.stk, b.rw, b.dr, b.dw, b.ra, b.sc};
    endfunction

    function automatic logic [63:0] exp2(input beat_t b);
        return {3'b0, b};
    endfunction

    function automatic logic [63:0] act1();
        return {14'b0, a_addr, b_addr, c_addr, immediate_val, addr, PC, alu_control,
                JCTL, im_ctl, stack_ctl, reg_write, data_read, data_write, reg_addr, stack_command};
    endfunction

    function automatic logic [63:0] act2();
        return {3'b0, d2_a, d2_b, d2_c, d2_imm, d2_addr, d2_pc, d2_alu,
                d2_jctl, d2_imc, d2_stk, d2_rw, d2_dr, d2_dw, d2_ra, d2_sc};
    endfunction

    task automatic drive1(input beat_t b, input logic v);
        cur = b;
        in_valid = v;
        a_addr_in = b.a[3:0];          b_addr_in = b.b[3:0];      c_addr_in = b.c[3:0];
        immediate_val_in = b.imm[7:0]; addr_in = b.addr;          PC_in = b.pc;
        alu_control_in = b.alu;        JCTL_in = b.jctl;          im_ctl_in = b.imc;
        stack_ctl_in = b.stk;          reg_write_in = b.rw;       data_read_in = b.dr;
        data_write_in = b.dw;          reg_addr_in = b.ra;        stack_command_in = b.sc;
    endtask

    task automatic drive2(input beat_t b, input logic v);
        cur2 = b;
        d2_in_valid = v;
        d2_a_in = b.a;       d2_b_in = b.b;       d2_c_in = b.c;      d2_imm_in = b.imm;
        d2_addr_in = b.addr; d2_pc_in = b.pc;     d2_alu_in = b.alu;  d2_jctl_in = b.jctl;
        d2_imc_in = b.imc;   d2_stk_in = b.stk;   d2_rw_in = b.rw;    d2_dr_in = b.dr;
        d2_dw_in = b.dw;     d2_ra_in = b.ra;     d2_sc_in = b.sc;
    endtask

    // Input monitors: record what each DUT will accept at the coming falling edge.
    initial forever begin
        @(posedge CLK);
        #2;
        if (RST || flush) q.delete();
        else if (in_valid && in_ready) q.push_back(cur);
    end

    initial forever begin
        @(posedge CLK);
        #2;
        if (RST || d2_flush) q2.delete();
        else if (d2_in_valid && d2_in_ready) begin
            q2.push_back(cur2);
            n_push2++;
        end
    end

    // Output monitors: compare every beat that execute consumes.
    initial forever begin
        @(posedge CLK);
        #1;
        if (!RST && !flush && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out1_unexpected: got PC %0h with no beat expected", PC);
            end else begin
                chk("out1_payload", act1(), exp1(q.pop_front()));
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (!RST && !d2_flush && d2_out_valid && d2_out_ready) begin
            n_pop2++;
            if (q2.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out2_unexpected: got PC %0h with no beat expected", d2_pc);
            end else begin
                chk("out2_payload", act2(), exp2(q2.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        last_acc = 1'b0;
        RST = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive1(mk(8'hEE, 1'b1, 1'b1), 1'b1);
        d2_flush = 1'b0;
        d2_out_ready = 1'b1;
        drive2(mk(8'h00, 1'b0, 1'b0), 1'b0);

        // Reset with in_valid held high
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_fields", act1(), 64'(0));
        chk("rst_stall", 64'(stall_count), 64'(0));
        chk("rst2_out_valid", 64'(d2_out_valid), 64'(0));
        chk("rst2_in_ready", 64'(d2_in_ready), 64'(1));
        chk("rst2_fields", act2(), 64'(0));
        chk("rst2_stall", 64'(d2_stall_count), 64'(0));
        @(posedge CLK);
        RST = 1'b0;
        in_valid = 1'b0;

        // Streaming PC 0x10..0x14, one-cycle latency, no gaps
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            drive1(mk(8'(8'h10 + i), 1'(i), 1'(i >> 1)), 1'b1);
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'(1));
            if (i == 0) chk("stream_first_empty", 64'(out_valid), 64'(0));
            else begin
                chk("stream_out_valid", 64'(out_valid), 64'(1));
                chk("stream_pc", 64'(PC), 64'(8'(8'h10 + i - 1)));
            end
        end
        @(posedge CLK);
        in_valid = 1'b0;
        #1;
        chk("stream_last_valid", 64'(out_valid), 64'(1));
        chk("stream_last_pc", 64'(PC), 64'(8'h14));
        chk("stream_no_stall", 64'(stall_count), 64'(0));

        // Stall and skid: 0x20 to main, 0x21 to skid, 0x22 held off
        @(posedge CLK);
        out_ready = 1'b0;
        drive1(mk(8'h20, 1'b0, 1'b1), 1'b1);
        #1;
        chk("stall_rdy0", 64'(in_ready), 64'(1));
        @(posedge CLK);
        drive1(mk(8'h21, 1'b1, 1'b0), 1'b1);
        #1;
        chk("stall_rdy1", 64'(in_ready), 64'(1));
        chk("stall_cnt0", 64'(stall_count), 64'(0));
        @(posedge CLK);
        drive1(mk(8'h22, 1'b1, 1'b1), 1'b1);
        #1;
        chk("stall_skid_full", 64'(in_ready), 64'(0));
        chk("stall_cnt1", 64'(stall_count), 64'(1));
        repeat (3) @(posedge CLK);
        out_ready = 1'b1;
        #1;
        chk("stall_cnt4", 64'(stall_count), 64'(4));
        chk("stall_held_off", 64'(in_ready), 64'(0));
        chk("stall_pc_stable", 64'(PC), 64'(8'h20));
        @(posedge CLK);
        #1;
        chk("release_rdy", 64'(in_ready), 64'(1));
        chk("release_pc", 64'(PC), 64'(8'h21));
        @(posedge CLK);
        in_valid = 1'b0;
        #1;
        chk("release_last_pc", 64'(PC), 64'(8'h22));
        @(posedge CLK);
        #1;
        chk("release_empty", 64'(out_valid), 64'(0));
        chk("release_cnt", 64'(stall_count), 64'(4));

        // Flush with both slots full
        out_ready = 1'b0;
        drive1(mk(8'h30, 1'b1, 1'b1), 1'b1);
        @(posedge CLK);
        drive1(mk(8'h31, 1'b1, 1'b1), 1'b1);
        @(posedge CLK);
        drive1(mk(8'h32, 1'b1, 1'b1), 1'b1);
        flush = 1'b1;
        #1;
        chk("preflush_valid", 64'(out_valid), 64'(1));
        chk("preflush_rw", 64'(reg_write), 64'(1));
        chk("preflush_dw", 64'(data_write), 64'(1));
        @(posedge CLK);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_rw_gated", 64'(reg_write), 64'(0));
        chk("flush_dw_gated", 64'(data_write), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        chk("flush_payload_kept", 64'(PC), 64'(8'h30));
        chk("flush_cnt", 64'(stall_count), 64'(6));
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("flush_stays_empty", 64'(out_valid), 64'(0));
        end

        // Flush coinciding with a drain and an accept
        @(posedge CLK);
        drive1(mk(8'h40, 1'b1, 1'b0), 1'b1);
        @(posedge CLK);
        drive1(mk(8'h41, 1'b1, 1'b1), 1'b1);
        flush = 1'b1;
        @(posedge CLK);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_drain_valid", 64'(out_valid), 64'(0));
        chk("flush_drain_cnt", 64'(stall_count), 64'(6));
        @(posedge CLK);
        #1;
        chk("flush_accept_squashed", 64'(out_valid), 64'(0));

        // Reset in the middle of a stall
        out_ready = 1'b0;
        drive1(mk(8'h50, 1'b1, 1'b1), 1'b1);
        @(posedge CLK);
        drive1(mk(8'h51, 1'b0, 1'b1), 1'b1);
        @(posedge CLK);
        in_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("midrst_pre_cnt", 64'(stall_count), 64'(7));
        chk("midrst_pre_rdy", 64'(in_ready), 64'(0));
        @(posedge CLK);
        RST = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_rdy", 64'(in_ready), 64'(1));
        chk("midrst_cnt", 64'(stall_count), 64'(0));
        chk("midrst_pc", 64'(PC), 64'(0));

        // Saturation on the 4-bit counter instance
        @(posedge CLK);
        d2_out_ready = 1'b0;
        drive2(mk(8'h60, 1'b1, 1'b0), 1'b1);
        @(posedge CLK);
        d2_in_valid = 1'b0;
        #1;
        chk("sat_cnt0", 64'(d2_stall_count), 64'(0));
        repeat (5) @(posedge CLK);
        #1;
        chk("sat_cnt5", 64'(d2_stall_count), 64'(5));
        repeat (15) @(posedge CLK);
        #1;
        chk("sat_cnt15", 64'(d2_stall_count), 64'(15));
        repeat (3) @(posedge CLK);
        #1;
        chk("sat_hold", 64'(d2_stall_count), 64'(15));
        chk("sat_pc_stable", 64'(d2_pc), 64'(8'h60));

        // Random traffic with back-pressure on the wide instance
        for (int n = 0; n < 300; n++) begin
            @(posedge CLK);
            if (!d2_in_valid || last_acc) drive2(rand_beat(), 1'($urandom_range(0, 3) != 0));
            d2_out_ready = ($urandom_range(0, 2) != 0);
            last_acc = d2_in_valid && d2_in_ready;
        end
        @(posedge CLK);
        d2_in_valid = 1'b0;
        d2_out_ready = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        chk("rand_drained", 64'(q2.size()), 64'(0));
        chk("rand_count", 64'(n_pop2), 64'(n_push2));
        chk("dir_drained", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_exec_pipe_reg.md
# decode_exec_pipe_reg

Parametrised decode-to-execute pipeline register for the 8-bit CPU: latches the full decoded instruction bundle (register addresses, immediate, address, PC, ALU/jump/immediate/stack controls, memory and register-write enables) between decode and execute. It adds valid/ready flow control with a two-entry skid buffer so execute can stall without losing a decoded instruction. It also supports flush for taken jumps, gates side-effecting enables on invalid slots, and keeps a saturating stall counter for debug.

## Interface
- REG_ADDR_W, 4, register-file address width (a/b/c addresses)
- DATA_W, 8, immediate value width
- ADDR_W, 8, data-memory address width
- PC_W, 8, program counter width
- ALU_CTL_W, 3, ALU control width
- STALL_CNT_W, 8, stall counter width
- CLK  in  1  clock; all state updates on the falling edge of CLK
- RST  in  1  synchronous, active-high reset, sampled on the falling edge of CLK
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  register can accept a beat this edge
- a_addr_in, b_addr_in, c_addr_in  in  REG_ADDR_W each  source/destination registers (c = a op b)
- immediate_val_in  in  DATA_W  immediate operand
- addr_in  in  ADDR_W  memory address
- PC_in  in  PC_W  instruction PC
- alu_control_in  in  ALU_CTL_W  ALU op
- JCTL_in, im_ctl_in, stack_ctl_in  in  2 each  jump, immediate and stack mode controls
- reg_write_in, data_read_in, data_write_in, reg_addr_in, stack_command_in  in  1 each  enables/selects
- flush  in  1  squash all held and incoming instructions
- out_valid  out  1  outputs hold a valid instruction
- out_ready  in  1  execute consumes the output this edge
- a_addr, b_addr, c_addr, immediate_val, addr, PC, alu_control, JCTL, im_ctl, stack_ctl, reg_addr  out  matching input widths  registered fields
- reg_write, data_read, data_write, stack_command  out  1 each  registered enables, forced 0 whenever out_valid = 0
- stall_count  out  STALL_CNT_W  saturating count of stalled edges

## Operation
- Two storage slots: main (drives outputs) and skid. Each slot has a valid bit.
- in_ready = ~skid_valid. It is registered, not combinational from out_ready.
- Accept: in_valid & in_ready at an edge.
- Drain: out_valid & out_ready at an edge.
- Slot rules per edge, excluding flush:
  - main empty or draining, skid empty: an accepted beat goes to main.
  - main full and not draining: an accepted beat goes to skid.
  - skid full and draining: skid moves to main and skid empties. No accept is possible in this case.
- flush: both valid bits clear; any beat accepted on the same edge is discarded. Payload registers keep their values, but gated enables read 0.
- Priority: RST > flush > normal flow.
- stall_count increments on every edge where out_valid & ~out_ready. It holds at all-ones and clears only on RST.
- Reset values:
  - out_valid = 0; skid empty; in_ready = 1.
  - All field outputs = 0; stall_count = 0.

## Timing
- Latency: a beat accepted at falling edge N appears on outputs with out_valid = 1 after edge N. Zero bubbles when out_ready is held high; throughput is 1 beat per cycle.
- in_ready reflects skid state after the previous edge. Decode must hold data while in_valid & ~in_ready.
- Once out_valid is 1, the output payload is stable until drained or flushed.
- After a stall is released, the skid entry is output one cycle later, and in_ready returns to 1 after that same edge.
- Simultaneous flush and out_ready: the drain is not counted as stalled, and the instruction is still squashed. Execute must ignore outputs sampled on a flush edge.
- RST mid-stall: both slots are emptied and stall_count clears on that edge.

## Structure
- Shared package cpu_pipe_pkg:
  - width constants (REG_ADDR_W, DATA_W, ADDR_W, PC_W, ALU_CTL_W)
  - JCTL, im_ctl and stack_ctl encodings
  - PAYLOAD_W, the sum of all field widths
- Fields are packed into a single PAYLOAD_W vector on entry and unpacked on exit.
- One generic sub-module, pipe_skid_buffer #(W), holds the two slots and the handshake. The top module adds the packing, flush, enable gating and stall counter.

## Test plan
- Reset: hold RST for 2 cycles with in_valid = 1 -> out_valid = 0, in_ready = 1, all fields 0, stall_count = 0.
- Streaming: out_ready = 1, feed PC 0x10..0x14 back-to-back -> outputs show PC 0x10..0x14 on consecutive cycles with one-cycle latency and no gaps.
- Stall and skid: with out_ready = 0, send PC 0x20 and then 0x21 -> in_ready drops to 0, and 0x22 is held off. stall_count counts the stalled edges. Releasing out_ready -> 0x20, 0x21, 0x22 in order with none lost.
- Flush: both slots full (PC 0x30, 0x31) with reg_write = 1 and data_write = 1, pulse flush together with in_valid at PC 0x32 -> out_valid = 0 and gated enables = 0 on the next cycle. 0x32 never appears on the outputs.
- Saturation: STALL_CNT_W = 4, stall for 20 cycles -> stall_count = 15 and it holds there.
- Parameters: REG_ADDR_W = 5 and DATA_W = 16 with random traffic and back-pressure -> output sequence matches a reference queue model field for field.
